icache_responder: RTL and testbench
===================================

# icache_responder

Direct-mapped, read-only instruction cache that answers the pipeline's instruction-fetch requests (`imemREN`/`imemaddr` → `ihit`/`imemload`) and services misses from the memory arbiter through a single-word `iREN`/`iaddr`/`iwait`/`iload` port. It sits between the datapath's fetch stage and the memory controller. A hit returns in the same cycle. A miss stalls the fetch stage by holding `ihit` low until the line is filled.

## Interface
- `SETS`, 16: number of one-word lines; power of two, 2..256; `IDX = log2(SETS)`.
- `CLK` input 1: clock, rising-edge.
- `nRST` input 1: reset, synchronous, active-low.
- `imemREN` input 1: fetch request from datapath.
- `imemaddr` input 32: fetch byte address; bits [1:0] ignored.
- `ihit` output 1: requested word valid this cycle; datapath uses it as PC write enable.
- `imemload` output 32: instruction word; 0 when `ihit`=0.
- `iREN` output 1: memory read request.
- `iaddr` output 32: memory word address, bits [1:0]=0.
- `iwait` input 1: memory busy; `iload` valid in the cycle `iwait`=0 while `iREN`=1.
- `iload` input 32: memory read data.
- `iflush` input 1: invalidate all lines (pulse).

## Operation
- Address split: tag = `imemaddr[31:IDX+2]`, index = `imemaddr[IDX+1:2]`.
- Storage: per line, a valid bit, a tag, and a 32-bit word.
- FSM states:
  - IDLE:
    - Hit = `imemREN` & valid[index] & tag match. When set, `ihit`=1 and `imemload`=data[index] combinationally.
    - A miss (`imemREN`=1 and not a hit) latches `imemaddr[31:2]` into `missaddr` and moves to FILL.
    - `imemREN`=0 stays in IDLE with `ihit`=0.
  - FILL:
    - `iREN`=1, `iaddr`={`missaddr`,2'b00}, `ihit`=0 (see Configuration).
    - The first cycle with `iwait`=0 writes the line at `missaddr`'s index: valid=1, tag from `missaddr`, data=`iload`. The state returns to IDLE.
- The fill always uses the latched `missaddr`. If `imemaddr` changes during FILL, the outstanding fill still completes, and the new address is looked up in IDLE.
- `iflush`=1:
  - In IDLE: clears all valid bits at the next edge; `ihit` is forced to 0 that cycle.
  - In FILL: the in-flight fill completes but does not set valid; all other valid bits clear.
- `imemREN`=0 during FILL has no effect; the fill completes.

## Timing
- Reset values (synchronous, `nRST`=0 at a rising edge):
  - state=IDLE, all valid=0, `missaddr`=0.
  - Therefore `iREN`=0, `iaddr`=0, `ihit`=0, `imemload`=0.
  - Tag and data arrays are not reset.
- Reset asserted during FILL abandons the fill: `iREN` drops at that edge and no line is written.
- Hit latency: 0 cycles (combinational from `imemaddr` and array state).
- Miss latency, without forwarding:
  - Cycle 0: miss detected in IDLE.
  - FILL lasts 1+N cycles, where N = number of `iwait`=1 cycles.
  - The hit appears the cycle after the fill write.
  - Total stall = N+2 cycles when `iwait` is already low on the first FILL cycle? No: with `iwait`=0 on the first FILL cycle, total stall = 2 cycles.
- `iREN` and `iaddr` are stable for the whole of FILL and deasserted (`iaddr`=0) in IDLE.
- Same-index different-tag misses overwrite the line; there is no replacement choice.

## Configuration
- `ICACHE_FWD_EN` defined:
  - In the FILL cycle where `iwait`=0, if `imemREN`=1 and `imemaddr[31:2]`==`missaddr`, then `ihit`=1 and `imemload`=`iload` in that same cycle.
  - This saves one stall cycle.
- `ICACHE_FWD_EN` undefined: `ihit`=0 throughout FILL, and the hit comes from the array in the following IDLE cycle.

## Test plan
- Reset, then `imemREN`=1, `imemaddr`=0x0000_0040, memory `iwait`=1 for 3 cycles then `iload`=0x2001_0005:
  - `iREN`=1 and `iaddr`=0x40 for 4 cycles.
  - `ihit`=1 with `imemload`=0x2001_0005 on the next cycle (or on the `iwait`=0 cycle with `ICACHE_FWD_EN`).
- Re-fetch 0x40 after the fill: `ihit`=1 the same cycle, `iREN`=0, no memory traffic.
- Conflict:
  - With SETS=16, fill 0x40, then fetch 0x80 (same index 0, different tag) → miss and refill.
  - A subsequent fetch of 0x40 misses again.
- Change `imemaddr` from 0x40 to 0x44 mid-FILL:
  - `iaddr` stays 0x40 until `iwait`=0 and the 0x40 line is written.
  - Then a miss fills 0x44; no forwarded hit for 0x44.
- Pulse `iflush` after filling 0x40 and 0x44: both then miss; `ihit`=0 in the flush cycle.
- Drive `nRST`=0 for one edge during FILL:
  - `iREN`=0 and `ihit`=0 next cycle.
  - Fetching the aborted address misses again.

Source files
------------

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped, read-only, one-word-per-line instruction cache.
//
// The fetch stage reads through imemREN/imemaddr. A hit returns ihit/imemload in the
// same cycle. On a miss the cache stalls the fetch stage by holding ihit low. It then
// fills the line with a single-word read on iREN/iaddr, and iwait/iload complete that
// read.
//
// Ports:
//   CLK, nRST        clock (rising edge), synchronous active-low reset
//   imemREN/imemaddr fetch request and byte address (bits [1:0] ignored)
//   ihit/imemload    fetch word valid and data (data is 0 when ihit=0)
//   iREN/iaddr       memory read request and word address (0 when idle)
//   iwait/iload      memory busy and read data (data valid when iwait=0)
//   iflush           invalidate all lines
//
// Optional feature: define ICACHE_FWD_EN to forward iload to the fetch stage in the
// FILL cycle that completes a fill for the currently requested word.
module icache_responder #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        iflush
);

    localparam int unsigned IDX  = $clog2(SETS);
    localparam int unsigned TAGW = 30 - IDX;

    typedef enum logic {
        StIdle,
        StFill
    } state_e;

    state_e           state_q, state_d;
    logic [SETS-1:0]  valid_q, valid_d;
    logic [29:0]      missaddr_q, missaddr_d;
    // A flush seen at any point during a fill keeps that fill from marking its line valid.
    logic             flush_pend_q, flush_pend_d;

    logic [TAGW-1:0]  tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    logic [IDX-1:0]   req_idx;
    logic [TAGW-1:0]  req_tag;
    logic [IDX-1:0]   miss_idx;
    logic [TAGW-1:0]  miss_tag;
    logic             lookup_hit;
    logic             fill_we;

    logic             unused_byte_offset;
    assign unused_byte_offset = ^imemaddr[1:0];

    assign req_idx  = imemaddr[IDX+1:2];
    assign req_tag  = imemaddr[31:IDX+2];
    assign miss_idx = missaddr_q[IDX-1:0];
    assign miss_tag = missaddr_q[29:IDX];

    // An invalid line masks its (unreset) tag, so the tag compare never sees X on a hit.
    assign lookup_hit = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        missaddr_d   = missaddr_q;
        flush_pend_d = flush_pend_q;
        fill_we      = 1'b0;
        ihit         = 1'b0;
        imemload     = '0;
        iREN         = 1'b0;
        iaddr        = '0;

        unique case (state_q)
            StIdle: begin
                if (iflush) begin
                    valid_d = '0;
                end
                // A flush cycle never hits, so a request made in that cycle becomes a miss.
                if (lookup_hit && !iflush) begin
                    ihit     = 1'b1;
                    imemload = data_q[req_idx];
                end else if (imemREN) begin
                    missaddr_d   = imemaddr[31:2];
                    flush_pend_d = 1'b0;
                    state_d      = StFill;
                end
            end

            StFill: begin
                iREN  = 1'b1;
                iaddr = {missaddr_q, 2'b00};
                if (iflush) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b1;
                end
                if (!iwait) begin
                    fill_we           = 1'b1;
                    valid_d[miss_idx] = !(iflush || flush_pend_q);
                    flush_pend_d      = 1'b0;
                    state_d           = StIdle;
`ifdef ICACHE_FWD_EN
                    if (imemREN && (imemaddr[31:2] == missaddr_q)) begin
                        ihit     = 1'b1;
                        imemload = iload;
                    end
`endif
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            missaddr_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            missaddr_q   <= missaddr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Tag and data storage is not reset; a reset edge suppresses the write so an aborted
    // fill leaves nothing behind.
    always_ff @(posedge CLK) begin
        if (nRST && fill_we) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder. A line-level reference model tracks, per
// set, the word address it holds, its data and its valid bit. It also tracks whether a
// fill is outstanding. Every cycle the directed and random scenarios compare the DUT
// outputs against that model. They also check key points against literal values.
module tb_icache_responder;

    localparam int unsigned SETS = 16;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        iflush;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    icache_responder #(.SETS(SETS)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .imemREN (imemREN),
        .imemaddr(imemaddr),
        .ihit    (ihit),
        .imemload(imemload),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .iflush  (iflush)
    );

    always #5 CLK = ~CLK;

    // Reference model: each set remembers which word address it holds.
    bit          m_valid [SETS];
    logic [29:0] m_line  [SETS];
    logic [31:0] m_data  [SETS];
    bit          m_fill;
    bit          m_fpend;
    logic [29:0] m_miss;

    bit          n_fill, n_fpend, n_we, n_wvalid, n_clear;
    logic [29:0] n_miss;
    logic [31:0] n_wdata;

    logic        exp_ihit;
    logic [31:0] exp_load;
    logic        exp_iren;
    logic [31:0] exp_iaddr;

    task automatic model_eval();
        logic [29:0] wa;
        int unsigned idx;
        wa        = imemaddr[31:2];
        idx       = int'(wa % SETS);
        exp_ihit  = 1'b0;
        exp_load  = '0;
        exp_iren  = 1'b0;
        exp_iaddr = '0;
        n_fill    = m_fill;
        n_fpend   = m_fpend;
        n_miss    = m_miss;
        n_we      = 1'b0;
        n_wvalid  = 1'b0;
        n_clear   = iflush;
        n_wdata   = iload;
        if (!m_fill) begin
            if (imemREN && m_valid[idx] && m_line[idx] == wa && !iflush) begin
                exp_ihit = 1'b1;
                exp_load = m_data[idx];
            end else if (imemREN) begin
                n_fill  = 1'b1;
                n_miss  = wa;
                n_fpend = 1'b0;
            end
        end else begin
            exp_iren  = 1'b1;
            exp_iaddr = {m_miss, 2'b00};
            if (iflush) n_fpend = 1'b1;
            if (!iwait) begin
                n_we     = 1'b1;
                n_wvalid = !(iflush || m_fpend);
                n_fill   = 1'b0;
                n_fpend  = 1'b0;
`ifdef ICACHE_FWD_EN
                if (imemREN && wa == m_miss) begin
                    exp_ihit = 1'b1;
                    exp_load = iload;
                end
`endif
            end
        end
    endtask

    task automatic model_commit();
        int unsigned idx;
        if (!nRST) begin
            m_fill  = 1'b0;
            m_fpend = 1'b0;
            m_miss  = '0;
            for (int k = 0; k < SETS; k++) m_valid[k] = 1'b0;
        end else begin
            if (n_clear) begin
                for (int k = 0; k < SETS; k++) m_valid[k] = 1'b0;
            end
            if (n_we) begin
                idx          = int'(m_miss % SETS);
                m_line[idx]  = m_miss;
                m_data[idx]  = n_wdata;
                m_valid[idx] = n_wvalid;
            end
            m_fill  = n_fill;
            m_fpend = n_fpend;
            m_miss  = n_miss;
        end
    endtask

    task automatic drive(input bit rst_n, input bit ren, input logic [31:0] addr,
                         input bit wt, input logic [31:0] ld, input bit fl);
        nRST     = rst_n;
        imemREN  = ren;
        imemaddr = addr;
        iwait    = wt;
        iload    = ld;
        iflush   = fl;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        repeat (2) begin
            @(posedge CLK); #1; model_commit();
        end
        drive(1'b1, 1'b0, 32'h40, 1'b1, 32'h0, 1'b0);
        @(negedge CLK); model_eval();
        chk_cnt++;
        if ({ihit, imemload, iREN, iaddr} !== 66'h0)
            $display("FAIL reset_outputs: got ihit=%b load=%h iREN=%b iaddr=%h, want all 0",
                     ihit, imemload, iREN, iaddr);
        else pass_cnt++;
        @(posedge CLK); #1; model_commit();
    endtask

    task automatic test_miss_fill();
        int iren_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 32'h40, (i < 4), 32'h2001_0005, 1'b0);
            @(negedge CLK); model_eval();
            chk_cnt++;
            if ({ihit, imemload, iREN, iaddr} !== {exp_ihit, exp_load, exp_iren, exp_iaddr})
                $display("FAIL miss_fill step %0d: got %b %h %b %h want %b %h %b %h", i,
                         ihit, imemload, iREN, iaddr, exp_ihit, exp_load, exp_iren, exp_iaddr);
            else pass_cnt++;
            if (iREN === 1'b1 && iaddr === 32'h40) iren_cycles++;
            if (i == 5) begin
                chk_cnt++;
                if (ihit !== 1'b1 || imemload !== 32'h2001_0005)
                    $display("FAIL miss_fill_hit: got ihit=%b load=%h want 1 20010005",
                             ihit, imemload);
                else pass_cnt++;
            end
            @(posedge CLK); #1; model_commit();
        end
        chk_cnt++;
        if (iren_cycles !== 4)
            $display("FAIL miss_fill_iren_len: got %0d cycles want 4", iren_cycles);
        else pass_cnt++;
    endtask

    task automatic test_refetch();
        drive(1'b1, 1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF, 1'b0);
        @(negedge CLK); model_eval();
        chk_cnt++;
        if ({ihit, imemload, iREN, iaddr} !== {1'b1, 32'h2001_0005, 1'b0, 32'h0})
            $display("FAIL refetch: got %b %h %b %h want 1 20010005 0 00000000",
                     ihit, imemload, iREN, iaddr);
        else pass_cnt++;
        @(posedge CLK); #1; model_commit();
    endtask

    task automatic test_conflict();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, (i < 3) ? 32'h80 : 32'h40, 1'b0,
                  (i < 3) ? 32'h1111_2222 : 32'h2001_0005, 1'b0);
            @(negedge CLK); model_eval();
            chk_cnt++;
            if ({ihit, imemload, iREN, iaddr} !== {exp_ihit, exp_load, exp_iren, exp_iaddr})
                $display("FAIL conflict step %0d: got %b %h %b %h want %b %h %b %h", i,
                         ihit, imemload, iREN, iaddr, exp_ihit, exp_load, exp_iren, exp_iaddr);
            else pass_cnt++;
            if (i == 3) begin
                chk_cnt++;
                if (ihit !== 1'b0)
                    $display("FAIL conflict_evict: got ihit=%b want 0", ihit);
                else pass_cnt++;
            end
            @(posedge CLK); #1; model_commit();
        end
    endtask

    task automatic test_addr_change();
        logic        ren, fl, wt;
        logic [31:0] addr, ld;
        for (int i = 0; i < 8; i++) begin
            ren  = (i != 0);
            fl   = (i == 0);
            addr = (i == 1 || i == 7) ? 32'h40 : 32'h44;
            wt   = (i == 1 || i == 2);
            ld   = (i < 4) ? 32'hA5A5_0040 : 32'h5A5A_0044;
            drive(1'b1, ren, addr, wt, ld, fl);
            @(negedge CLK); model_eval();
            chk_cnt++;
            if ({ihit, imemload, iREN, iaddr} !== {exp_ihit, exp_load, exp_iren, exp_iaddr})
                $display("FAIL addr_change step %0d: got %b %h %b %h want %b %h %b %h", i,
                         ihit, imemload, iREN, iaddr, exp_ihit, exp_load, exp_iren, exp_iaddr);
            else pass_cnt++;
            if (i == 2 || i == 3) begin
                chk_cnt++;
                if (iaddr !== 32'h40 || iREN !== 1'b1 || ihit !== 1'b0)
                    $display("FAIL addr_change_hold: got iaddr=%h iREN=%b ihit=%b want 40 1 0",
                             iaddr, iREN, ihit);
                else pass_cnt++;
            end
            if (i == 7) begin
                chk_cnt++;
                if (ihit !== 1'b1 || imemload !== 32'hA5A5_0040)
                    $display("FAIL addr_change_old_line: got ihit=%b load=%h want 1 a5a50040",
                             ihit, imemload);
                else pass_cnt++;
            end
            @(posedge CLK); #1; model_commit();
        end
    endtask

    task automatic test_flush();
        logic        fl;
        logic [31:0] addr, ld;
        for (int i = 0; i < 8; i++) begin
            fl   = (i == 1 || i == 4);
            addr = (i < 3) ? 32'h44 : 32'h40;
            ld   = (i < 3) ? 32'h0BAD_0044 : 32'h0C0D_0040;
            drive(1'b1, 1'b1, addr, 1'b0, ld, fl);
            @(negedge CLK); model_eval();
            chk_cnt++;
            if ({ihit, imemload, iREN, iaddr} !== {exp_ihit, exp_load, exp_iren, exp_iaddr})
                $display("FAIL flush step %0d: got %b %h %b %h want %b %h %b %h", i,
                         ihit, imemload, iREN, iaddr, exp_ihit, exp_load, exp_iren, exp_iaddr);
            else pass_cnt++;
            if (i == 1 || i == 3 || i == 5) begin
                chk_cnt++;
                if (ihit !== 1'b0)
                    $display("FAIL flush_miss step %0d: got ihit=%b want 0", i, ihit);
                else pass_cnt++;
            end
            if (i == 2) begin
                chk_cnt++;
                if (iREN !== 1'b1 || iaddr !== 32'h44)
                    $display("FAIL flush_refill: got iREN=%b iaddr=%h want 1 44", iREN, iaddr);
                else pass_cnt++;
            end
            @(posedge CLK); #1; model_commit();
        end
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 6; i++) begin
            drive((i != 2), 1'b1, 32'h48, (i < 3), 32'h7777_0048, 1'b0);
            @(negedge CLK); model_eval();
            chk_cnt++;
            if ({ihit, imemload, iREN, iaddr} !== {exp_ihit, exp_load, exp_iren, exp_iaddr})
                $display("FAIL reset_abort step %0d: got %b %h %b %h want %b %h %b %h", i,
                         ihit, imemload, iREN, iaddr, exp_ihit, exp_load, exp_iren, exp_iaddr);
            else pass_cnt++;
            if (i == 3) begin
                chk_cnt++;
                if (iREN !== 1'b0 || ihit !== 1'b0 || iaddr !== 32'h0)
                    $display("FAIL reset_abort_drop: got iREN=%b ihit=%b iaddr=%h want 0 0 0",
                             iREN, ihit, iaddr);
                else pass_cnt++;
            end
            @(posedge CLK); #1; model_commit();
        end
    endtask

    task automatic test_random();
        logic [25:0] tags [4];
        logic [31:0] addr;
        bit          rst_n, ren, wt, fl;
        tags[0] = 26'h0;
        tags[1] = 26'h1;
        tags[2] = 26'h3FF_FFFF;
        tags[3] = 26'h2AA_AAAA;
        addr    = 32'h40;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0)
                addr = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
                        2'($urandom_range(0, 3))};
            rst_n = ($urandom_range(0, 99) != 0);
            ren   = ($urandom_range(0, 4) != 0);
            wt    = ($urandom_range(0, 2) == 0);
            fl    = ($urandom_range(0, 39) == 0);
            drive(rst_n, ren, addr, wt, $urandom, fl);
            @(negedge CLK); model_eval();
            chk_cnt++;
            if ({ihit, imemload, iREN, iaddr} !== {exp_ihit, exp_load, exp_iren, exp_iaddr})
                $display("FAIL random cycle %0d: got %b %h %b %h want %b %h %b %h", i,
                         ihit, imemload, iREN, iaddr, exp_ihit, exp_load, exp_iren, exp_iaddr);
            else pass_cnt++;
            @(posedge CLK); #1; model_commit();
        end
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_refetch();
        test_conflict();
        test_addr_change();
        test_flush();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
